// File: rtl/mul8_seq_ctrl_if.sv
// Request/response bundle between a requester and mul8_seq_ctrl.
// The in_acc member exists only when MUL8_SEQ_ACC_EN is defined.
interface mul8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
`ifdef MUL8_SEQ_ACC_EN
    logic        in_acc;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    modport master (
`ifdef MUL8_SEQ_ACC_EN
        output in_acc,
`endif
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
`ifdef MUL8_SEQ_ACC_EN
        input  in_acc,
`endif
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply sequenced over a shared 4x4 multiplier in four nibble passes.
// Optional feature macro: MUL8_SEQ_ACC_EN (accumulate onto the previous product).
module mul8_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mul8_seq_ctrl_if.slave bus,
    output logic           busy,
    output logic [3:0]     mul_a,
    output logic [3:0]     mul_b,
    input  logic [7:0]     mul_p
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MUL_LAT);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc_r;
    logic [15:0] product_r;
    logic [1:0]  wait_r;
    logic        last_s;
    logic [15:0] pp_s;
    logic [15:0] acc_sum_s;
    logic [15:0] acc_init_s;

    assign last_s        = (wait_r == WAIT_LAST);
    assign acc_sum_s     = acc_r + pp_s;
    assign bus.in_ready  = (state_r == S_IDLE);
    assign bus.out_valid = (state_r == S_DONE);
    assign bus.product   = product_r;
    assign busy          = (state_r != S_IDLE);

    // Accumulator start value chosen at accept time.
    always_comb begin
`ifdef MUL8_SEQ_ACC_EN
        if (bus.in_acc) begin
            acc_init_s = product_r;
        end else begin
            acc_init_s = 16'h0000;
        end
`else
        acc_init_s = 16'h0000;
`endif
    end

    // Nibble operand select and shifted partial product for each pass.
    always_comb begin
        mul_a = 4'h0;
        mul_b = 4'h0;
        pp_s  = 16'h0000;
        case (state_r)
            S_P0: begin
                mul_a = a_r[3:0];
                mul_b = b_r[3:0];
                pp_s  = {8'h00, mul_p};
            end
            S_P1: begin
                mul_a = a_r[7:4];
                mul_b = b_r[3:0];
                pp_s  = {4'h0, mul_p, 4'h0};
            end
            S_P2: begin
                mul_a = a_r[3:0];
                mul_b = b_r[7:4];
                pp_s  = {4'h0, mul_p, 4'h0};
            end
            S_P3: begin
                mul_a = a_r[7:4];
                mul_b = b_r[7:4];
                pp_s  = {mul_p, 8'h00};
            end
            default: begin
                mul_a = 4'h0;
                mul_b = 4'h0;
                pp_s  = 16'h0000;
            end
        endcase
    end

    // Next-state decode; each pass holds until the wait counter reaches MUL_LAT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_s = S_P0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_P0: state_s = last_s ? S_P1 : S_P0;
            S_P1: state_s = last_s ? S_P2 : S_P1;
            S_P2: state_s = last_s ? S_P3 : S_P2;
            S_P3: state_s = last_s ? S_DONE : S_P3;
            S_DONE: begin
                if (bus.out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, operand capture, wait counter and shift-accumulate datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            acc_r     <= 16'h0000;
            product_r <= 16'h0000;
            wait_r    <= 2'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.in_a;
                        b_r    <= bus.in_b;
                        acc_r  <= acc_init_s;
                        wait_r <= 2'd0;
                    end
                end
                S_P0, S_P1, S_P2, S_P3: begin
                    if (last_s) begin
                        acc_r  <= acc_sum_s;
                        wait_r <= 2'd0;
                        // product only moves when the final pass lands, so it stays
                        // stable through compute and usable as the accumulate base.
                        if (state_r == S_P3) begin
                            product_r <= acc_sum_s;
                        end
                    end else begin
                        wait_r <= wait_r + 2'd1;
                    end
                end
                default: begin
                    wait_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul8_seq_ctrl.md
# mul8_seq_ctrl

Sequencer that computes an 8x8 unsigned product using the existing combinational 4x4 array multiplier as its only multiplier. It splits each operand into nibbles, drives the four nibble pairs through the shared 4x4 multiplier over four partial-product states, and shift-accumulates the results into a 16-bit product. It sits between a valid/ready requester and the 4x4 multiplier instance, whose operand and product pins are its `mul_*` ports.

## Interface

Parameters:
- `MUL_LAT`, default 0: extra cycles the 4x4 multiplier needs before `mul_p` is valid. Legal range 0..3.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  request carries valid operands.
- `in_ready`  out  1  block can accept a request.
- `in_a`  in  8  multiplicand, unsigned.
- `in_b`  in  8  multiplier, unsigned.
- `in_acc`  in  1  accumulate request; present only with `MUL8_SEQ_ACC_EN`.
- `out_valid`  out  1  `product` holds a finished result.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  16  result register.
- `busy`  out  1  high in any state other than IDLE.
- `mul_a`  out  4  nibble operand to the 4x4 multiplier.
- `mul_b`  out  4  nibble operand to the 4x4 multiplier.
- `mul_p`  in  8  product from the 4x4 multiplier.

## Operation

- States: IDLE, P0, P1, P2, P3, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `in_a`, `in_b` (and `in_acc`), load the accumulator, and go to P0.
- Partial-product states drive `mul_a`/`mul_b` from the registered operands:
  - P0: aL·bL, shift 0.
  - P1: aH·bL, shift 4.
  - P2: aL·bH, shift 4.
  - P3: aH·bH, shift 8.
- Each Pk state lasts 1+`MUL_LAT` cycles, timed by a wait counter. On its last cycle the block adds `{8'b0,mul_p} << shift` to the 16-bit accumulator and advances. After P3 the next state is DONE.
- The accumulator initialises to 0. In accumulate mode it initialises to the current `product` value instead. All addition is modulo 2^16.
- DONE: `product` equals the accumulator and `out_valid`=1. `product` is held stable until `out_valid && out_ready`, which returns the block to IDLE. `product` keeps its value after the handshake.
- Outside P0..P3, `mul_a` and `mul_b` are 0.
- `in_valid` outside IDLE is ignored, and `in_ready`=0.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=16'h0000, `mul_a`=0, `mul_b`=0, wait counter 0.
- `in_ready`, `busy`, `out_valid`, `mul_a` and `mul_b` are decoded from registered state only. No combinational path runs from `in_valid`/`out_ready` to any output.
- `mul_p` is sampled only on the last cycle of each Pk state. The path `mul_a`/`mul_b` → `mul_p` is combinational when `MUL_LAT`=0.
- Latency: `out_valid` rises 4·(1+`MUL_LAT`) cycles after the accept edge.
- Minimum initiation interval is 4·(1+`MUL_LAT`)+2 cycles: accept, compute, DONE handshake, then IDLE.
- When `out_ready` is already high on entry to DONE, `out_valid` is high for exactly one cycle.
- Asserting `rst_n` low in any state, including mid-P2 or a stalled DONE, immediately forces the reset values. The in-flight operation is discarded. After reset release the block resumes in IDLE.

## Configuration

- `MUL8_SEQ_ACC_EN` defined:
  - The `in_acc` port exists.
  - When `in_acc`=1 at accept, the new product is added to the previous `product` (wrapping at 16 bits).
  - When `in_acc`=0 at accept, the accumulator starts at 0.
- `MUL8_SEQ_ACC_EN` undefined:
  - The `in_acc` port is absent.
  - The accumulator always starts at 0.

## Test plan

- `MUL_LAT`=0; `in_a`=0xFF, `in_b`=0xFF accepted → `out_valid` exactly 4 cycles after the accept edge, `product`=0xFE01. `mul_a`/`mul_b` sequence is (F,F),(F,F),(F,F),(F,F).
- `in_a`=0x3C, `in_b`=0xA5 → 0x26AC; `in_a`=0x00, `in_b`=0x7F → 0x0000. `mul_a`/`mul_b` read (C,5),(3,5),(C,A),(3,A) for the first operation.
- Hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 and new operands → `product` stable, `in_ready`=0, new request not taken. The handshake returns the block to IDLE and the next request is accepted.
- Pull `rst_n` low during P2 → same cycle: `out_valid`=0, `busy`=0, `product`=0, `in_ready`=1. Then 0x12·0x34 after release → 0x03A8.
- `MUL_LAT`=2: 0x0F·0x11 → `product`=0x00FF with `out_valid` 12 cycles after accept. `mul_p` is sampled on the 3rd cycle of each Pk.
- With `MUL8_SEQ_ACC_EN`: 0xFF·0xFF (`in_acc`=0) → 0xFE01, then 0xFF·0xFF (`in_acc`=1) → 0xFC02 (wrap), then 0x10·0x10 (`in_acc`=0) → 0x0100.
